// File: rtl/l2_mem_sched.sv
// L2 memory scheduler: arbitrates L2 refills and writebacks onto a single memory
// port with one transaction in flight, writeback-first priority and a starvation bound.
module l2_mem_sched #(
    parameter int MEM_LAT    = 3,
    parameter int WB_CYC     = 2,
    parameter int MAX_WB_RUN = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         miss_req,
    input  logic [2:0]   miss_gid,
    input  logic         wb_req,
    input  logic [2:0]   wb_gid,
    input  logic [127:0] wb_data,
    output logic         miss_ack,
    output logic [127:0] refill_data,
    output logic         wb_ack,
    output logic         err,
    output logic         mem_l2_miss,
    output logic         mem_en_back,
    output logic [2:0]   mem_group_id,
    inout  wire  [127:0] mem_data,
    input  logic         mem_error
);

    localparam int CNT_MAX = (MEM_LAT > WB_CYC) ? MEM_LAT : WB_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int RW      = $clog2(MAX_WB_RUN + 1);

    localparam logic [CW-1:0] WB_LAST   = CW'(WB_CYC - 1);
    localparam logic [CW-1:0] MISS_LAST = CW'(MEM_LAT - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(MAX_WB_RUN);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB   = 3'd1,
        MISS = 3'd2,
        TURN = 3'd3,
        ACK  = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]  run_q, run_d;
    logic           is_miss_q, is_miss_d;
    logic           err_q, err_d;
    logic [2:0]     gid_q, gid_d;
    logic [127:0]   refill_q, refill_d;
    logic [127:0]   wdata_q, wdata_d;

    logic           grant_wb;
    logic           grant_miss;

    // Writeback wins unless it has already starved a waiting miss for MAX_WB_RUN grants.
    always_comb begin
        grant_wb   = wb_req && !(miss_req && (run_q == RUN_MAX));
        grant_miss = miss_req && !grant_wb;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_miss_d = is_miss_q;
        err_d     = err_q;
        gid_d     = gid_q;
        refill_d  = refill_q;
        wdata_d   = wdata_q;

        case (state_q)
            IDLE: begin
                if (grant_wb) begin
                    state_d   = WB;
                    cnt_d     = '0;
                    is_miss_d = 1'b0;
                    err_d     = 1'b0;
                    gid_d     = wb_gid;
                    wdata_d   = wb_data;
                end else if (grant_miss) begin
                    state_d   = MISS;
                    cnt_d     = '0;
                    is_miss_d = 1'b1;
                    err_d     = 1'b0;
                    gid_d     = miss_gid;
                end
            end
            WB: begin
                err_d = err_q | mem_error;
                if (cnt_q == WB_LAST) begin
                    state_d = TURN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MISS: begin
                err_d = err_q | mem_error;
                if (cnt_q == MISS_LAST) begin
                    state_d  = ACK;
                    refill_d = mem_data;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // One dead cycle lets our bus driver release before memory may drive.
            TURN: begin
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        run_d = run_q;
        if (!miss_req) begin
            run_d = '0;
        end else if ((state_q == IDLE) && grant_wb) begin
            if (run_q != RUN_MAX) begin
                run_d = run_q + RW'(1);
            end
        end else if ((state_q == IDLE) && grant_miss) begin
            run_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            run_q     <= '0;
            is_miss_q <= 1'b0;
            err_q     <= 1'b0;
            gid_q     <= '0;
            refill_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            is_miss_q <= is_miss_d;
            err_q     <= err_d;
            gid_q     <= gid_d;
            refill_q  <= refill_d;
        end
    end

    // Write data is only observed while en_back is high, so it needs no reset.
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
    end

    always_comb begin
        mem_l2_miss  = (state_q == MISS);
        mem_en_back  = (state_q == WB);
        miss_ack     = (state_q == ACK) && is_miss_q;
        wb_ack       = (state_q == ACK) && !is_miss_q;
        err          = (state_q == ACK) && err_q;
        mem_group_id = gid_q;
        refill_data  = refill_q;
    end

    assign mem_data = mem_en_back ? wdata_q : {128{1'bz}};

endmodule
